isq_scheduler: RTL and testbench
================================

# isq_scheduler

Allocation and oldest-first issue controller for an array of `DEPTH` issue-queue condition entries. It tracks which entries are occupied, steers each enqueue into a free entry via a one-hot write enable, and keeps a relative-age matrix between entries. Each cycle it selects the oldest occupied entry whose ready flag is set and issues it through a valid/ready handshake. It sits between rename/dispatch and the execution-unit port, and drives the entry array's `wr_en` and `clear_entry` strobes.

## Interface
- `DEPTH`, 8: number of entries; must be ≥2.
- `INDEX_WIDTH`, 3: equals $clog2(DEPTH).
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  squash every entry this cycle; highest priority.
- `enq_valid`  in  1  dispatch presents an instruction.
- `enq_ready`  out  1  at least one entry is free and `flush`=0.
- `enq_wr_en`  out  DEPTH  one-hot write strobe to the allocated entry; all-zero when there is no enqueue fire.
- `enq_idx`  out  INDEX_WIDTH  index of the allocated entry; valid when `enq_ready`=1.
- `entry_ready`  in  DEPTH  per-entry ready_to_dequeue from the entry array.
- `iss_valid`  out  1  an issuable entry exists.
- `iss_ready`  in  1  execution port accepts.
- `iss_sel`  out  DEPTH  one-hot selected entry; zero when `iss_valid`=0.
- `iss_idx`  out  INDEX_WIDTH  index of the selected entry.
- `clear_entry`  out  DEPTH  clear strobe to the entry array: the one-hot `iss_sel` on issue fire, all-ones on `flush`.
- `count`  out  INDEX_WIDTH+1  registered occupancy.

## Operation
- State:
  - `busy[DEPTH]`, the occupancy flags.
  - `older[DEPTH][DEPTH]`: `older[i][j]`=1 means entry i was enqueued before entry j.
  - `count`.
- Reset: `busy`=0, `older`=0, `count`=0.
- Allocation: `free` = ~`busy`, taken from the registered `busy` at cycle start. `enq_idx` = lowest-index free entry.
- `enq_fire` = `enq_valid` & `enq_ready`.
- On `enq_fire` to entry k:
  - `busy[k]`←1.
  - For every j with `busy[j]`=1 at cycle start: `older[j][k]`←1 and `older[k][j]`←0.
- Select:
  - `cand[i]` = `busy[i]` & `entry_ready[i]`.
  - Entry i is chosen if `cand[i]`=1 and there is no j with `cand[j]` & `older[j][i]`.
  - Exactly one entry is chosen when `cand` is non-zero.
- `iss_valid` = |`cand` & ~`flush`.
- `iss_fire` = `iss_valid` & `iss_ready`. On `iss_fire` to entry s: `busy[s]`←0. Row and column s of `older` may be left stale; they are masked by `busy` and rewritten at the next allocation.
- Issue and enqueue in the same cycle:
  - Both are allowed, to different entries.
  - An entry freed by issue is not reallocated until the next cycle, because allocation uses start-of-cycle `busy`.
  - The new entry is younger than every surviving entry. Its relation to the issuing entry is irrelevant.
- `count` next value = `count` + `enq_fire` − `iss_fire`, with no wrap. It always equals popcount(`busy`).
- Flush:
  - `enq_ready`=0 and `iss_valid`=0 in the flush cycle, so no fire occurs.
  - `clear_entry`=all-ones.
  - Next state: `busy`=0, `older`=0, `count`=0.
- Full (`count`=DEPTH): `enq_ready`=0 and `enq_wr_en`=0.
- Empty: `iss_valid`=0 regardless of `entry_ready`.
- `entry_ready` bits on non-busy entries are ignored.

## Timing
- All handshake outputs are combinational from registered state plus `flush`, `enq_valid` and `entry_ready` (and `iss_ready` for `clear_entry`). There are no combinational paths from `iss_ready` to `iss_valid` or from `enq_valid` to `enq_ready`.
- Enqueue to issue eligibility: an entry written at edge N may appear in `iss_sel` in cycle N+1 if its `entry_ready` is 1.
- Selection is not held stable across cycles. A newly ready older entry preempts the prior candidate the following cycle.
- Reset mid-operation: all state returns to reset values asynchronously. After reset deassertion, `enq_ready`=1 and `iss_valid`=0.
- Throughput is one enqueue plus one issue per cycle.

## Test plan
- Reset then three enqueues (DEPTH=8) with `entry_ready`=0 → `enq_idx` 0,1,2; `count`=3; `iss_valid`=0.
- Age order: enqueue into entries 0,1,2, issue entry 0, enqueue again (goes to entry 0), then set all `entry_ready`=1 → issue order is 1, 2, 0, and each fire pulses the matching `clear_entry` one-hot.
- Fill all 8 entries → `enq_ready`=0 at `count`=8. Then issue and enqueue in the same cycle → enqueue is blocked that cycle; the next cycle reuses the freed index.
- Readiness preemption: entries 0 (oldest) and 3 are busy; `entry_ready`=0b1000 gives `iss_idx`=3; then `entry_ready`=0b1001 with `iss_ready`=0 gives `iss_idx`=0.
- Flush with 5 busy entries and `enq_valid`=1 → `clear_entry`=0xFF, no enqueue or issue fire, `count`=0 next cycle, and the next enqueue gets `enq_idx`=0.
- Assert `reset_n` low mid-stream with 4 busy → `count`=0 immediately. After release, random enq/issue traffic for 10k cycles must show `count` = popcount(`busy`), a one-hot `iss_sel`, and oldest-first issue against a reference FIFO-age model.

Source files
------------

// File: rtl/isq_scheduler.sv
// Issue-queue scheduler: lowest-free-entry allocation plus age-matrix oldest-ready selection.
// Handshake outputs are combinational from registered busy/age state; flush squashes every entry.
module isq_scheduler #(
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  output logic [DEPTH-1:0]       enq_wr_en,
  output logic [INDEX_WIDTH-1:0] enq_idx,
  input  logic [DEPTH-1:0]       entry_ready,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [DEPTH-1:0]       iss_sel,
  output logic [INDEX_WIDTH-1:0] iss_idx,
  output logic [DEPTH-1:0]       clear_entry,
  output logic [INDEX_WIDTH:0]   count
);

  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [DEPTH-1:0][DEPTH-1:0] older_next;
  logic [DEPTH-1:0]            free;
  logic [DEPTH-1:0]            alloc_oh;
  logic [DEPTH-1:0]            cand;
  logic [DEPTH-1:0]            blocked;
  logic [DEPTH-1:0]            chosen;
  logic                        enq_fire;
  logic                        iss_fire;

  assign free      = ~busy;
  // Two's-complement trick isolates the lowest set bit of the free mask.
  assign alloc_oh  = free & (~free + 1'b1);
  assign enq_ready = ~flush & (|free);
  assign enq_fire  = enq_valid & enq_ready;
  assign enq_wr_en = enq_fire ? alloc_oh : '0;

  always_comb begin
    enq_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) enq_idx = enq_idx | INDEX_WIDTH'(i);
    end
  end

  assign cand = busy & entry_ready;

  // An entry is blocked when any older candidate exists; age is a total order over busy entries.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        blocked[i] = blocked[i] | (cand[j] & older[j][i]);
      end
    end
    chosen = cand & ~blocked;
  end

  assign iss_valid = ~flush & (|cand);
  assign iss_sel   = iss_valid ? chosen : '0;
  assign iss_fire  = iss_valid & iss_ready;

  always_comb begin
    iss_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (chosen[i]) iss_idx = iss_idx | INDEX_WIDTH'(i);
    end
  end

  assign clear_entry = flush ? '1 : (iss_fire ? iss_sel : '0);

  // New entry is younger than everything busy at cycle start; stale rows of free entries stay masked.
  always_comb begin
    older_next = older;
    for (int k = 0; k < DEPTH; k++) begin
      if (enq_wr_en[k]) begin
        older_next[k] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          older_next[j][k] = busy[j];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= '0;
      older <= '0;
      count <= '0;
    end else if (flush) begin
      busy  <= '0;
      older <= '0;
      count <= '0;
    end else begin
      busy  <= (busy & ~clear_entry) | enq_wr_en;
      older <= older_next;
      count <= count + {{INDEX_WIDTH{1'b0}}, enq_fire} - {{INDEX_WIDTH{1'b0}}, iss_fire};
    end
  end

endmodule

// File: tb/tb_isq_scheduler.sv
// Directed and randomized checks of isq_scheduler allocation, oldest-first issue, flush and reset.
module tb_isq_scheduler;

  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [DEPTH-1:0] enq_wr_en;
  logic [IW-1:0]   enq_idx;
  logic [DEPTH-1:0] entry_ready;
  logic            iss_valid;
  logic            iss_ready;
  logic [DEPTH-1:0] iss_sel;
  logic [IW-1:0]   iss_idx;
  logic [DEPTH-1:0] clear_entry;
  logic [IW:0]     count;

  int total = 0;
  int bad   = 0;

  isq_scheduler #(.DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_wr_en(enq_wr_en), .enq_idx(enq_idx),
    .entry_ready(entry_ready), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_sel(iss_sel), .iss_idx(iss_idx), .clear_entry(clear_entry), .count(count)
  );

  always #5 clock = ~clock;

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    flush = 1'b0; enq_valid = 1'b0; iss_ready = 1'b0; entry_ready = '0;
  endtask

  task automatic do_reset;
    idle();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic enq_n(input int n);
    for (int k = 0; k < n; k++) begin
      enq_valid = 1'b1;
      cyc();
    end
    enq_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle();
    cyc(); cyc();
    reset_n = 1'b1;
    #2;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
    total++; if (clear_entry !== 8'h00) begin bad++; $display("FAIL reset_clear got=%h exp=00", clear_entry); end
    cyc();
  endtask

  task automatic test_alloc;
    logic [DEPTH-1:0] exp_oh;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1;
      #2;
      exp_oh = 8'h01 << k;
      total++; if (enq_idx !== IW'(k)) begin bad++; $display("FAIL alloc_idx%0d got=%0d exp=%0d", k, enq_idx, k); end
      total++; if (enq_wr_en !== exp_oh) begin bad++; $display("FAIL alloc_wr_en%0d got=%h exp=%h", k, enq_wr_en, exp_oh); end
      cyc();
    end
    enq_valid = 1'b0;
    #2;
    total++; if (count !== 4'd3) begin bad++; $display("FAIL alloc_count got=%0d exp=3", count); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL alloc_iss_valid got=%b exp=0", iss_valid); end
    total++; if (enq_wr_en !== 8'h00) begin bad++; $display("FAIL alloc_wr_idle got=%h exp=00", enq_wr_en); end
  endtask

  task automatic test_age_order;
    int exp_order [3] = '{1, 2, 0};
    logic [DEPTH-1:0] exp_oh;
    do_reset();
    enq_n(3);
    entry_ready = 8'h01; iss_ready = 1'b1;
    #2;
    total++; if (clear_entry !== 8'h01) begin bad++; $display("FAIL age_first_clear got=%h exp=01", clear_entry); end
    cyc();
    idle(); enq_valid = 1'b1;
    #2;
    total++; if (enq_idx !== 3'd0) begin bad++; $display("FAIL age_realloc got=%0d exp=0", enq_idx); end
    cyc();
    idle(); entry_ready = 8'hFF; iss_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #2;
      exp_oh = 8'h01 << exp_order[n];
      total++; if (iss_idx !== IW'(exp_order[n])) begin bad++; $display("FAIL age_order%0d got=%0d exp=%0d", n, iss_idx, exp_order[n]); end
      total++; if (clear_entry !== exp_oh) begin bad++; $display("FAIL age_clear%0d got=%h exp=%h", n, clear_entry, exp_oh); end
      cyc();
    end
    #2;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL age_empty_valid got=%b exp=0", iss_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL age_empty_count got=%0d exp=0", count); end
    idle();
  endtask

  task automatic test_full;
    do_reset();
    enq_n(8);
    enq_valid = 1'b1;
    #2;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", count); end
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_enq_ready got=%b exp=0", enq_ready); end
    total++; if (enq_wr_en !== 8'h00) begin bad++; $display("FAIL full_wr_en got=%h exp=00", enq_wr_en); end
    entry_ready = 8'hFF; iss_ready = 1'b1;
    #1;
    total++; if (iss_idx !== 3'd0) begin bad++; $display("FAIL full_iss_idx got=%0d exp=0", iss_idx); end
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_same_cycle_enq got=%b exp=0", enq_ready); end
    cyc();
    iss_ready = 1'b0;
    #2;
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL full_reuse_ready got=%b exp=1", enq_ready); end
    total++; if (enq_idx !== 3'd0) begin bad++; $display("FAIL full_reuse_idx got=%0d exp=0", enq_idx); end
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_count7 got=%0d exp=7", count); end
    cyc();
    idle();
    #2;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_refill got=%0d exp=8", count); end
  endtask

  task automatic test_preempt;
    do_reset();
    enq_n(4);
    entry_ready = 8'h06; iss_ready = 1'b1;
    cyc(); cyc();
    iss_ready = 1'b0; entry_ready = 8'h08;
    #2;
    total++; if (iss_idx !== 3'd3) begin bad++; $display("FAIL preempt_first got=%0d exp=3", iss_idx); end
    total++; if (iss_sel !== 8'h08) begin bad++; $display("FAIL preempt_sel got=%h exp=08", iss_sel); end
    cyc();
    entry_ready = 8'h09;
    #2;
    total++; if (iss_idx !== 3'd0) begin bad++; $display("FAIL preempt_older got=%0d exp=0", iss_idx); end
    total++; if (count !== 4'd2) begin bad++; $display("FAIL preempt_count got=%0d exp=2", count); end
    idle();
  endtask

  task automatic test_flush;
    do_reset();
    enq_n(5);
    flush = 1'b1; enq_valid = 1'b1; entry_ready = 8'hFF; iss_ready = 1'b1;
    #2;
    total++; if (clear_entry !== 8'hFF) begin bad++; $display("FAIL flush_clear got=%h exp=ff", clear_entry); end
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL flush_enq_ready got=%b exp=0", enq_ready); end
    total++; if (enq_wr_en !== 8'h00) begin bad++; $display("FAIL flush_wr_en got=%h exp=00", enq_wr_en); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_iss_valid got=%b exp=0", iss_valid); end
    cyc();
    idle(); enq_valid = 1'b1;
    #2;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (enq_idx !== 3'd0) begin bad++; $display("FAIL flush_next_idx got=%0d exp=0", enq_idx); end
    cyc();
    idle();
  endtask

  task automatic test_reset_mid;
    do_reset();
    enq_n(4);
    entry_ready = 8'hFF;
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", count); end
    reset_n = 1'b1;
    #1;
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL midreset_enq_ready got=%b exp=1", enq_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL midreset_iss_valid got=%b exp=0", iss_valid); end
    idle();
    cyc();
  endtask

  task automatic test_random;
    logic [DEPTH-1:0] mbusy;
    int               age_q[$];
    int               exp_enq, exp_iss;
    logic             exp_enq_rdy, exp_iss_vld;
    logic [DEPTH-1:0] exp_sel;
    mbusy = '0;
    age_q.delete();
    for (int c = 0; c < 10000; c++) begin
      flush       = ($urandom_range(63) == 0);
      enq_valid   = ($urandom_range(3) != 0);
      iss_ready   = ($urandom_range(2) != 0);
      entry_ready = DEPTH'($urandom);
      #2;
      exp_enq = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!mbusy[i]) exp_enq = i;
      exp_enq_rdy = !flush && (exp_enq >= 0);
      exp_iss = -1;
      for (int q = age_q.size() - 1; q >= 0; q--) if (entry_ready[age_q[q]]) exp_iss = age_q[q];
      exp_iss_vld = !flush && (exp_iss >= 0);
      exp_sel = exp_iss_vld ? (8'h01 << exp_iss) : 8'h00;
      total++; if (count !== 4'(age_q.size())) begin bad++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, age_q.size()); end
      total++; if (enq_ready !== exp_enq_rdy) begin bad++; $display("FAIL rand_enq_ready c=%0d got=%b exp=%b", c, enq_ready, exp_enq_rdy); end
      total++; if (iss_valid !== exp_iss_vld) begin bad++; $display("FAIL rand_iss_valid c=%0d got=%b exp=%b", c, iss_valid, exp_iss_vld); end
      total++; if (iss_sel !== exp_sel) begin bad++; $display("FAIL rand_iss_sel c=%0d got=%h exp=%h", c, iss_sel, exp_sel); end
      if (exp_enq_rdy) begin
        total++; if (enq_idx !== IW'(exp_enq)) begin bad++; $display("FAIL rand_enq_idx c=%0d got=%0d exp=%0d", c, enq_idx, exp_enq); end
      end
      if (flush) begin
        mbusy = '0;
        age_q.delete();
      end else begin
        if (exp_iss_vld && iss_ready) begin
          mbusy[exp_iss] = 1'b0;
          for (int q = 0; q < age_q.size(); q++) if (age_q[q] == exp_iss) begin age_q.delete(q); break; end
        end
        if (exp_enq_rdy && enq_valid) begin
          mbusy[exp_enq] = 1'b1;
          age_q.push_back(exp_enq);
        end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    test_reset();
    test_alloc();
    test_age_order();
    test_full();
    test_preempt();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
